// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: FSM encodings, status bit
// positions, common keyboard command bytes and the frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_WAITIDLE
  } state_t;

  localparam int STAT_DONE    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_ACK_ERR = 2;
  localparam int STAT_TIMEOUT = 3;
  localparam int STAT_OVFL    = 4;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  // Bit 0 is the start bit, bit 10 the stop bit; parity is odd over the byte.
  function automatic logic [10:0] build_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Three-flop synchroniser for the PS/2 clock and data pads with a one-cycle
// pulse on each synchronised falling edge of the PS/2 clock.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [2:0] clk_sr;
  logic [2:0] dat_sr;
  logic       clk_prev;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sr   <= 3'b111;
      dat_sr   <= 3'b111;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= {clk_sr[1:0], ps2_clk_in};
      dat_sr   <= {dat_sr[1:0], ps2_dat_in};
      clk_prev <= clk_sr[2];
    end
  end

  assign clk_sync = clk_sr[2];
  assign dat_sync = dat_sr[2];
  assign clk_fall = clk_prev & ~clk_sr[2];

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: two-register bus peripheral that runs the
// inhibit / request-to-send / device-clocked sequence on open-drain enables.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 1600,
  parameter int RTS_CYC     = 16,
  parameter int TIMEOUT_CYC = 240000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit
);

  localparam int PH_MAX = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYC - 1);
  localparam logic [PH_W-1:0] RTS_LAST = PH_W'(RTS_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  logic clk_sync;
  logic dat_sync;
  logic clk_fall;

  ps2_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_sync   (clk_sync),
    .dat_sync   (dat_sync),
    .clk_fall   (clk_fall)
  );

  state_t          state, state_next;
  logic [PH_W-1:0] phase_cnt, phase_next;
  logic [3:0]      bitcnt, bitcnt_next;
  logic [TO_W-1:0] to_cnt, to_next;
  logic [10:0]     frame, frame_next;
  logic [7:0]      data_reg, data_next;
  logic            done, done_next;
  logic            ack_err, ack_err_next;
  logic            timeout, timeout_next;
  logic            ovfl, ovfl_next;
  logic            clk_oe_next, dat_oe_next;
  logic            clr;
  logic [7:0]      status;

  logic wr_ctrl, wr_data, rd_any, rd_ctrl, soft_rst;

  assign wr_ctrl = cs & we & ~addr;
  assign wr_data = cs & we & addr;
  assign rd_any  = cs & ~we;
  assign rd_ctrl = rd_any & ~addr;

  // A clr write takes effect on the same edge it is written, like rst does.
  assign soft_rst = rst | clr | (wr_ctrl & din[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      clr <= 1'b0;
    end else if (wr_ctrl) begin
      clr <= din[0];
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      bitcnt     <= '0;
      to_cnt     <= '0;
      frame      <= '0;
      data_reg   <= '0;
      done       <= 1'b0;
      ack_err    <= 1'b0;
      timeout    <= 1'b0;
      ovfl       <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      state      <= state_next;
      phase_cnt  <= phase_next;
      bitcnt     <= bitcnt_next;
      to_cnt     <= to_next;
      frame      <= frame_next;
      data_reg   <= data_next;
      done       <= done_next;
      ack_err    <= ack_err_next;
      timeout    <= timeout_next;
      ovfl       <= ovfl_next;
      ps2_clk_oe <= clk_oe_next;
      ps2_dat_oe <= dat_oe_next;
    end
  end

  // Next-state logic; the pad enables are decoded from the next state so they
  // come straight out of flops and cannot glitch onto the open-drain pads.
  always_comb begin
    state_next   = state;
    phase_next   = phase_cnt;
    bitcnt_next  = bitcnt;
    to_next      = to_cnt;
    frame_next   = frame;
    data_next    = data_reg;
    done_next    = done;
    ack_err_next = ack_err;
    timeout_next = timeout;
    ovfl_next    = ovfl;

    if (rd_ctrl) begin
      done_next = 1'b0;
    end

    if (wr_data && (state != ST_IDLE)) begin
      ovfl_next = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (wr_data) begin
          data_next    = din;
          frame_next   = build_frame(din);
          done_next    = 1'b0;
          ack_err_next = 1'b0;
          timeout_next = 1'b0;
          phase_next   = '0;
          state_next   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (phase_cnt == INH_LAST) begin
          phase_next = '0;
          state_next = ST_RTS;
        end else begin
          phase_next = phase_cnt + PH_W'(1);
        end
      end
      ST_RTS: begin
        if (phase_cnt == RTS_LAST) begin
          phase_next  = '0;
          bitcnt_next = '0;
          to_next     = '0;
          state_next  = ST_SEND;
        end else begin
          phase_next = phase_cnt + PH_W'(1);
        end
      end
      ST_SEND: begin
        if (clk_fall) begin
          bitcnt_next = bitcnt + 4'd1;
          if (bitcnt == 4'd9) begin
            state_next = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          ack_err_next = dat_sync;
          state_next   = ST_WAITIDLE;
        end
      end
      ST_WAITIDLE: begin
        if (clk_sync && dat_sync) begin
          done_next  = ~ack_err;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Watchdog over the device-clocked part of the frame; it overrides
    // whatever the state above decided.
    if ((state == ST_SEND) || (state == ST_ACK) || (state == ST_WAITIDLE)) begin
      if (to_cnt == TO_LAST) begin
        timeout_next = 1'b1;
        done_next    = 1'b0;
        state_next   = ST_IDLE;
      end else begin
        to_next = to_cnt + TO_W'(1);
      end
    end

    clk_oe_next = (state_next == ST_INHIBIT) || (state_next == ST_RTS);
    dat_oe_next = (state_next == ST_RTS) ||
                  ((state_next == ST_SEND) && !frame_next[bitcnt_next]);
  end

  always_comb begin
    status               = '0;
    status[STAT_DONE]    = done;
    status[STAT_BUSY]    = (state != ST_IDLE);
    status[STAT_ACK_ERR] = ack_err;
    status[STAT_TIMEOUT] = timeout;
    status[STAT_OVFL]    = ovfl;
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      dout <= '0;
    end else if (rd_any) begin
      dout <= addr ? data_reg : status;
    end
  end

  assign rx_inhibit = (state != ST_IDLE);

endmodule
